// File: rtl/top_level2.sv
// top_level2: two-cycle accumulator CPU with a fixed 16x8 ROM program and 16x8 data RAM.
// Define TOP_LEVEL2_MUL_EN to implement opcode E as a 4x4 multiply; otherwise it is a NOP.
module top_level2 (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   output logic [3:0] pc,
   output logic [7:0] acc,
   output logic [7:0] out_port,
   output logic       out_valid,
   output logic       zero,
   output logic       carry,
   output logic       halted
);

   typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

   state_e     state, state_d;
   logic [7:0] ir, ir_d;
   logic [7:0] ram [16];
   logic [3:0] pc_d;
   logic [7:0] acc_d, out_port_d;
   logic       out_valid_d, zero_d, carry_d, halted_d;
   logic       ram_we, upd_z;
   logic [7:0] rom_data;
   logic [3:0] n;
   logic [7:0] operand;
   logic [8:0] wide;

   assign n       = ir[3:0];
   assign operand = ram[n];

   always_comb begin
      case (pc)
         4'd0:    rom_data = 8'h15;
         4'd1:    rom_data = 8'h30;
         4'd2:    rom_data = 8'h13;
         4'd3:    rom_data = 8'h40;
         4'd4:    rom_data = 8'hD0;
         4'd5:    rom_data = 8'h50;
         4'd6:    rom_data = 8'hE0;
         4'd7:    rom_data = 8'hD0;
         4'd8:    rom_data = 8'hF0;
         default: rom_data = 8'h00;
      endcase
   end

   always_comb begin
      state_d     = state;
      pc_d        = pc;
      ir_d        = ir;
      acc_d       = acc;
      zero_d      = zero;
      carry_d     = carry;
      out_port_d  = out_port;
      out_valid_d = 1'b0;
      halted_d    = halted;
      ram_we      = 1'b0;
      upd_z       = 1'b0;
      wide        = 9'h000;
      if (enable) begin
         case (state)
            StFetch: begin
               ir_d    = rom_data;
               pc_d    = pc + 4'd1;
               state_d = StExec;
            end
            StExec: begin
               state_d = StFetch;
               case (ir[7:4])
                  4'h1: begin acc_d = {4'h0, n}; upd_z = 1'b1; end
                  4'h2: begin acc_d = operand; upd_z = 1'b1; end
                  4'h3: ram_we = 1'b1;
                  4'h4: begin
                     wide    = {1'b0, acc} + {1'b0, operand};
                     acc_d   = wide[7:0];
                     carry_d = wide[8];
                     upd_z   = 1'b1;
                  end
                  4'h5: begin
                     // bit 8 of the 9-bit difference is the borrow
                     wide    = {1'b0, acc} - {1'b0, operand};
                     acc_d   = wide[7:0];
                     carry_d = wide[8];
                     upd_z   = 1'b1;
                  end
                  4'h6: begin acc_d = acc & operand; upd_z = 1'b1; end
                  4'h7: begin acc_d = acc | operand; upd_z = 1'b1; end
                  4'h8: begin acc_d = acc ^ operand; upd_z = 1'b1; end
                  4'h9: begin acc_d = ~acc; upd_z = 1'b1; end
                  4'hA: begin
                     carry_d = acc[7];
                     acc_d   = {acc[6:0], 1'b0};
                     upd_z   = 1'b1;
                  end
                  4'hB: pc_d = n;
                  4'hC: if (zero) pc_d = n;
                  4'hD: begin out_port_d = acc; out_valid_d = 1'b1; end
`ifdef TOP_LEVEL2_MUL_EN
                  4'hE: begin
                     acc_d   = {4'h0, acc[3:0]} * {4'h0, operand[3:0]};
                     carry_d = 1'b0;
                     upd_z   = 1'b1;
                  end
`endif
                  4'hF: begin state_d = StHalt; halted_d = 1'b1; end
                  default: ;
               endcase
               if (upd_z) zero_d = (acc_d == 8'h00);
            end
            StHalt:  ;
            default: state_d = StFetch;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= StFetch;
         pc        <= 4'h0;
         ir        <= 8'h00;
         acc       <= 8'h00;
         zero      <= 1'b0;
         carry     <= 1'b0;
         out_port  <= 8'h00;
         out_valid <= 1'b0;
         halted    <= 1'b0;
         for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
      end else begin
         state     <= state_d;
         pc        <= pc_d;
         ir        <= ir_d;
         acc       <= acc_d;
         zero      <= zero_d;
         carry     <= carry_d;
         out_port  <= out_port_d;
         out_valid <= out_valid_d;
         halted    <= halted_d;
         if (ram_we) ram[n] <= acc;
      end
   end

endmodule

// File: tb/tb_top_level2.sv
// Scoreboarded bench for top_level2: instruction-level ISS predicts OUT values and per-cycle state
// under random enable patterns, enable gaps, asynchronous mid-run resets and post-halt cycles.
module tb_top_level2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [3:0] pc;
   logic [7:0] acc, out_port;
   logic       out_valid, zero, carry, halted;

   top_level2 dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .pc       (pc),
      .acc      (acc),
      .out_port (out_port),
      .out_valid(out_valid),
      .zero     (zero),
      .carry    (carry),
      .halted   (halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cycle;
      int value;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail = 0;
   int   k_now = 0;

   int rom [16] = '{'h15, 'h30, 'h13, 'h40, 'hD0, 'h50, 'hE0, 'hD0, 'hF0,
                    'h00, 'h00, 'h00, 'h00, 'h00, 'h00, 'h00};
   int n_instr;
   int pc_f [32];
   int pc_e [32];
   int acc_e [32];
   int z_e [32];
   int c_e [32];
   int out_e [32];
   int out_idx[$];
   int out_val[$];

   task automatic check(input string name, input int act, input int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Executes the ROM one whole instruction at a time and records the state after each.
   task automatic iss_build();
      int p = 0, a = 0, z = 0, c = 0, o = 0, op, nn, ins, s;
      int ram [16];
      bit stop = 1'b0;
      for (int i = 0; i < 16; i++) ram[i] = 0;
      n_instr = 0;
      while (!stop && n_instr < 32) begin
         ins = rom[p];
         p = (p + 1) % 16;
         pc_f[n_instr] = p;
         op = ins / 16;
         nn = ins % 16;
         case (op)
            1:  begin a = nn; z = int'(a == 0); end
            2:  begin a = ram[nn]; z = int'(a == 0); end
            3:  ram[nn] = a;
            4:  begin s = a + ram[nn]; c = int'(s > 255); a = s % 256; z = int'(a == 0); end
            5:  begin c = int'(a < ram[nn]); a = (a - ram[nn] + 256) % 256; z = int'(a == 0); end
            6:  begin a = a & ram[nn]; z = int'(a == 0); end
            7:  begin a = a | ram[nn]; z = int'(a == 0); end
            8:  begin a = a ^ ram[nn]; z = int'(a == 0); end
            9:  begin a = 255 - a; z = int'(a == 0); end
            10: begin c = int'(a >= 128); a = (a * 2) % 256; z = int'(a == 0); end
            11: p = nn;
            12: if (z != 0) p = nn;
            13: begin o = a; out_idx.push_back(n_instr); out_val.push_back(a); end
`ifdef TOP_LEVEL2_MUL_EN
            14: begin a = (a % 16) * (ram[nn] % 16); c = 0; z = int'(a == 0); end
`endif
            15: stop = 1'b1;
            default: ;
         endcase
         pc_e[n_instr]  = p;
         acc_e[n_instr] = a;
         z_e[n_instr]   = z;
         c_e[n_instr]   = c;
         out_e[n_instr] = o;
         n_instr++;
      end
   endtask

   // Each instruction costs two enabled cycles; k counts enabled cycles since reset.
   task automatic check_state(input string tag, input int k);
      int i = k / 2;
      int e_pc, e_acc, e_z, e_c, e_out;
      if (i == 0) begin
         e_pc = 0; e_acc = 0; e_z = 0; e_c = 0; e_out = 0;
      end else begin
         e_pc = pc_e[i-1]; e_acc = acc_e[i-1]; e_z = z_e[i-1]; e_c = c_e[i-1];
         e_out = out_e[i-1];
      end
      if (k % 2 == 1) e_pc = pc_f[i];
      check({tag, " pc"}, int'(pc), e_pc);
      check({tag, " acc"}, int'(acc), e_acc);
      check({tag, " zero"}, int'(zero), e_z);
      check({tag, " carry"}, int'(carry), e_c);
      check({tag, " out_port"}, int'(out_port), e_out);
      check({tag, " halted"}, int'(halted), int'(k == 2 * n_instr));
   endtask

   task automatic check_zero(input string tag);
      check({tag, " pc"}, int'(pc), 0);
      check({tag, " acc"}, int'(acc), 0);
      check({tag, " out_port"}, int'(out_port), 0);
      check({tag, " out_valid"}, int'(out_valid), 0);
      check({tag, " zero"}, int'(zero), 0);
      check({tag, " carry"}, int'(carry), 0);
      check({tag, " halted"}, int'(halted), 0);
   endtask

   task automatic do_reset();
      enable = 1'b0;
      reset  = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;
   endtask

   task automatic run_program(input int en_pct, input int abort_at, input int gap_at);
      int   kmax = 2 * n_instr;
      int   k = 0, post = 0, cyc = 0, gap_left = 0;
      bit   gap_done = 1'b0;
      exp_t t;
      exp_q.delete();
      foreach (out_idx[j]) begin
         t.cycle = 2 * (out_idx[j] + 1);
         t.value = out_val[j];
         exp_q.push_back(t);
      end
      k_now = 0;
      while (post < 10) begin
         if (gap_at != 0 && k == gap_at && !gap_done) begin
            gap_left = 5;
            gap_done = 1'b1;
         end
         if (gap_left > 0) begin
            enable = 1'b0;
            gap_left--;
         end else if (k == kmax) enable = 1'b1;
         else enable = ($urandom_range(99) < en_pct);
         @(posedge clk);
         if (enable) begin
            if (k < kmax) k++;
            else post++;
         end
         k_now = k;
         @(negedge clk);
         check_state("run", k);
         cyc++;
         if (abort_at != 0 && k == abort_at) begin
            #2 reset = 1'b1;
            #1 check_zero("async reset");
            exp_q.delete();
            k_now = 0;
            return;
         end
         if (cyc > 600) begin
            check("run cycle budget", cyc, 600);
            return;
         end
      end
      check("pending outs", exp_q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         if (exp_q.size() == 0) check("out_valid extra", int'(out_valid), 0);
         else begin
            mon_e = exp_q.pop_front();
            check("out value", int'(out_port), mon_e.value);
            check("out cycle", k_now, mon_e.cycle);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      iss_build();
      do_reset();
      run_program(100, 0, 0);
      check("final pc", int'(pc), 9);
      check("final halted", int'(halted), 1);
      check("final carry", int'(carry), 0);
      check("final zero", int'(zero), 0);
`ifdef TOP_LEVEL2_MUL_EN
      check("final acc", int'(acc), 15);
      check("final out_port", int'(out_port), 15);
`else
      check("final acc", int'(acc), 3);
      check("final out_port", int'(out_port), 3);
`endif
      do_reset();
      run_program(100, 0, 4);
      for (int r = 0; r < 3; r++) begin
         do_reset();
         run_program(40 + 20 * r, 0, 0);
      end
      do_reset();
      run_program(100, 7, 0);
      do_reset();
      run_program(100, 0, 0);
      do_reset();
      run_program(70, int'($urandom_range(17, 1)), 0);
      do_reset();
      run_program(60, 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
